// File: rtl/lcd_hd44780_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_pkg
// Description : Shared definitions for the HD44780 bus responder: instruction
//               decode masks, DDRAM line bounds, fill character, FSM states
//               and the address-counter step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_hd44780_pkg;

  // FSM states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Instruction masks: the highest set bit selects the instruction
  localparam logic [7:0] INS_SET_AC  = 8'h80;
  localparam logic [7:0] INS_CGRAM   = 8'h40;
  localparam logic [7:0] INS_FUNC    = 8'h20;
  localparam logic [7:0] INS_SHIFT   = 8'h10;
  localparam logic [7:0] INS_DISPLAY = 8'h08;
  localparam logic [7:0] INS_ENTRY   = 8'h04;
  localparam logic [7:0] INS_HOME    = 8'h02;
  localparam logic [7:0] INS_CLEAR   = 8'h01;

  // Two 40-character lines: 0x00-0x27 and 0x40-0x67
  localparam logic [6:0] DDRAM_L1_END  = 7'h27;
  localparam logic [6:0] DDRAM_L2_BASE = 7'h40;
  localparam logic [6:0] DDRAM_L2_END  = 7'h67;
  localparam int         DDRAM_VALID   = 80;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= DDRAM_L1_END) || ((a >= DDRAM_L2_BASE) && (a <= DDRAM_L2_END));
  endfunction

  // Step the address counter, wrapping between the two lines
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == DDRAM_L1_END) return DDRAM_L2_BASE;
      if (ac == DDRAM_L2_END) return 7'h00;
      return ac + 7'd1;
    end
    if (ac == 7'h00) return DDRAM_L2_END;
    if (ac == DDRAM_L2_BASE) return DDRAM_L1_END;
    return ac - 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ddram
// Description : 128x8 display RAM, one write port and two registered read
//               ports (host bus and text overlay).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ddram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] bus_raddr,
  output logic [7:0] bus_rdata,
  input  logic [6:0] disp_raddr,
  output logic [7:0] disp_rdata
);

  logic [7:0] mem_q [128];
  logic [7:0] bus_rdata_q;
  logic [7:0] disp_rdata_q;

  // Single write port, two read-before-write registered read ports
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    bus_rdata_q  <= mem_q[bus_raddr];
    disp_rdata_q <= mem_q[disp_raddr];
  end

  assign bus_rdata  = bus_rdata_q;
  assign disp_rdata = disp_rdata_q;

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_responder
// Description : LCD-side responder of the HD44780 8-bit bus. Synchronizes the
//               host pins, executes the command/data subset into an 80-byte
//               DDRAM image, answers status/data reads and exposes the DDRAM
//               on an overlay read port.
//               Optional: LCD_RESP_OVERRUN_EN enables the sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES      = 1850,
  parameter int BUSY_LONG_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_MAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(BUSY_LONG_CYCLES - 1);
  // Gap between the end of line 1 and the start of line 2
  localparam logic [6:0] LINE_GAP = DDRAM_L2_BASE - (DDRAM_L1_END + 7'd1);

  logic [10:0] sync1_d, sync1_q, sync2_d, sync2_q;
  logic        e_prev_q;
  logic        e_s, rs_s, rw_s, e_rise, e_fall, write_commit, busy_w;
  logic [7:0]  data_s;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]      fill_q, fill_d, fill_addr;
  logic [6:0]      ac_q, ac_d;
  logic            id_q, id_d;
  logic            display_on_q, display_on_d;
  logic            cursor_on_q, cursor_on_d;
  logic            blink_on_q, blink_on_d;
  logic            rd_pend_q, rd_pend_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            disp_valid_q, disp_valid_d;

  logic            ram_we;
  logic [6:0]      ram_waddr;
  logic [7:0]      ram_wdata;
  logic [7:0]      bus_rdata, disp_rdata;

  assign sync1_d = {LCD_E, LCD_RS, LCD_RW, lcd_data_in};
  assign sync2_d = sync1_q;

  // Two-flop synchronizer on all host pins plus the E history bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      e_prev_q <= e_s;
    end
  end

  assign e_s          = sync2_q[10];
  assign rs_s         = sync2_q[9];
  assign rw_s         = sync2_q[8];
  assign data_s       = sync2_q[7:0];
  assign e_rise       = e_s & ~e_prev_q;
  assign e_fall       = ~e_s & e_prev_q;
  assign write_commit = e_fall & ~rw_s;
  assign busy_w       = (state_q != ST_IDLE);

  // Fill index 0..79 mapped onto the two visible lines
  assign fill_addr = (fill_q <= DDRAM_L1_END) ? fill_q : fill_q + LINE_GAP;

  // FSM state register; reset restarts the clear fill
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next state, command execution, RAM write port and read latching
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    ac_d         = ac_q;
    id_d         = id_q;
    display_on_d = display_on_q;
    cursor_on_d  = cursor_on_q;
    blink_on_d   = blink_on_q;
    rd_pend_d    = e_rise & rw_s;
    rd_data_d    = rd_data_q;
    disp_valid_d = addr_valid(disp_addr);
    ram_we       = 1'b0;
    ram_waddr    = fill_addr;
    ram_wdata    = FILL_CHAR;

    // Read data is captured one cycle after the rise so the RAM port has
    // already been addressed by the current AC
    if (rd_pend_q) rd_data_d = rs_s ? bus_rdata : {busy_w, ac_q};

    case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (fill_q == 7'(DDRAM_VALID - 1)) begin
          ac_d    = 7'h00;
          id_d    = 1'b1;
          cnt_d   = CNT_LONG;
          state_d = ST_BUSY;
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
      end
    endcase

    // Commits are only acted on from IDLE; writes while busy are dropped
    if (e_fall && !busy_w) begin
      if (rw_s) begin
        if (rs_s) ac_d = ac_step(ac_q, id_q);
      end else begin
        state_d = ST_BUSY;
        cnt_d   = CNT_SHORT;
        if (rs_s) begin
          ram_we    = 1'b1;
          ram_waddr = ac_q;
          ram_wdata = data_s;
          ac_d      = ac_step(ac_q, id_q);
        end else if (|(data_s & INS_SET_AC)) begin
          ac_d = addr_valid(data_s[6:0]) ? data_s[6:0] : 7'h00;
        end else if (|(data_s & INS_CGRAM)) begin
          // CGRAM address: accepted without effect
        end else if (|(data_s & INS_FUNC)) begin
          // Function set: only 8-bit mode exists, nothing to change
        end else if (|(data_s & INS_SHIFT)) begin
          if (!data_s[3]) ac_d = ac_step(ac_q, data_s[2]);
        end else if (|(data_s & INS_DISPLAY)) begin
          display_on_d = data_s[2];
          cursor_on_d  = data_s[1];
          blink_on_d   = data_s[0];
        end else if (|(data_s & INS_ENTRY)) begin
          id_d = data_s[1];
        end else if (|(data_s & INS_HOME)) begin
          ac_d  = 7'h00;
          cnt_d = CNT_LONG;
        end else if (|(data_s & INS_CLEAR)) begin
          state_d = ST_CLEAR;
          fill_d  = 7'h00;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      fill_q       <= 7'h00;
      ac_q         <= 7'h00;
      id_q         <= 1'b1;
      display_on_q <= 1'b0;
      cursor_on_q  <= 1'b0;
      blink_on_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_data_q    <= 8'h00;
      disp_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      ac_q         <= ac_d;
      id_q         <= id_d;
      display_on_q <= display_on_d;
      cursor_on_q  <= cursor_on_d;
      blink_on_q   <= blink_on_d;
      rd_pend_q    <= rd_pend_d;
      rd_data_q    <= rd_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

`ifdef LCD_RESP_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky: any write arriving while busy is recorded until reset
  always_comb overrun_d = overrun_q | (write_commit & busy_w);

  // Overrun flag register
  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  lcd_ddram u_ddram (
    .clk        (clk),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .bus_raddr  (ac_q),
    .bus_rdata  (bus_rdata),
    .disp_raddr (disp_addr),
    .disp_rdata (disp_rdata)
  );

  assign lcd_data_out = rd_data_q;
  assign lcd_data_oe  = e_s & rw_s;
  assign disp_data    = disp_valid_q ? disp_rdata : FILL_CHAR;
  assign cursor_addr  = ac_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign busy         = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hd44780_responder
// Description : Self-checking bench for lcd_hd44780_responder: directed bus
//               transactions plus randomized commands, compared against a
//               behavioural LCD model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;

  localparam int BC = 40;
  localparam int LC = 100;
`ifdef LCD_RESP_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [6:0] disp_addr = 7'h00;
  logic [7:0] disp_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, busy, overrun;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the display
  logic [7:0] m_mem [128];
  logic [6:0] m_ac;
  bit         m_id, m_disp, m_cur, m_blink, m_busy, m_ovr;

  always #5 clk = ~clk;

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .BUSY_LONG_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .disp_addr(disp_addr), .disp_data(disp_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid(input int a);
    return (a < 40) || (a >= 64 && a < 104);
  endfunction

  // Treat the 80 visible cells as one ring of positions
  function automatic logic [6:0] m_move(input logic [6:0] a, input bit inc);
    int pos;
    pos = (a < 64) ? int'(a) : int'(a) - 24;
    pos = (pos + (inc ? 1 : 79)) % 80;
    return (pos < 40) ? 7'(pos) : 7'(pos + 24);
  endfunction

  function automatic logic [7:0] m_overlay(input int a);
    return m_valid(a) ? m_mem[a] : 8'h20;
  endfunction

  // Returns the expected busy length, 0 for a dropped write
  function automatic int model_write(input bit rs, input logic [7:0] d);
    int dur;
    if (m_busy) begin
      if (OVR_EN) m_ovr = 1'b1;
      return 0;
    end
    dur = BC;
    if (rs) begin
      m_mem[m_ac] = d;
      m_ac = m_move(m_ac, m_id);
    end else if (d >= 8'h80) begin
      m_ac = m_valid(int'(d[6:0])) ? d[6:0] : 7'h00;
    end else if (d >= 8'h20) begin
      dur = BC;
    end else if (d >= 8'h10) begin
      if (!d[3]) m_ac = m_move(m_ac, d[2]);
    end else if (d >= 8'h08) begin
      m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
    end else if (d >= 8'h04) begin
      m_id = d[1];
    end else if (d >= 8'h02) begin
      m_ac = 7'h00;
      dur = LC;
    end else if (d == 8'h01) begin
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
      m_ac = 7'h00;
      m_id = 1'b1;
      dur = 80 + LC;
    end
    m_busy = 1'b1;
    return dur;
  endfunction

  task automatic wait_not_busy();
    for (int i = 0; i < 2000 && busy === 1'b1; i++) @(negedge clk);
    chk("idle_reached", busy, 1'b0);
    m_busy = 1'b0;
  endtask

  // Host write cycle; optionally measures the busy window it causes
  task automatic bus_write(input bit rs, input logic [7:0] d, input bit wait_idle);
    int exp_dur, n;
    exp_dur = model_write(rs, d);
    LCD_RS = rs; LCD_RW = 1'b0; lcd_data_in = d;
    @(negedge clk);
    LCD_E = 1'b1;
    repeat (5) @(negedge clk);
    LCD_E = 1'b0;
    if (wait_idle) begin
      n = 0;
      for (int i = 0; i < 8 && busy !== 1'b1; i++) @(negedge clk);
      while (busy === 1'b1 && n < exp_dur + 50) begin
        n++;
        @(negedge clk);
      end
      chk("busy_len", n, exp_dur);
      m_busy = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic bus_read(input bit rs, input string tag);
    logic [7:0] exp;
    exp = rs ? m_mem[m_ac] : {m_busy, m_ac};
    LCD_RS = rs; LCD_RW = 1'b1;
    @(negedge clk);
    LCD_E = 1'b1;
    repeat (6) @(negedge clk);
    chk({tag, "_oe"}, lcd_data_oe, 1'b1);
    chk(tag, lcd_data_out, exp);
    LCD_E = 1'b0;
    if (rs && !m_busy) m_ac = m_move(m_ac, m_id);
    repeat (4) @(negedge clk);
    LCD_RW = 1'b0;
  endtask

  task automatic check_overlay(input string tag);
    for (int a = 0; a < 128; a++) begin
      disp_addr = 7'(a);
      @(negedge clk);
      chk(tag, disp_data, m_overlay(a));
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ac"}, cursor_addr, m_ac);
    chk({tag, "_flags"}, {display_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
  endtask

  initial begin
    int n;
    logic [7:0] r;
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
    m_busy = 1'b0; m_ovr = 1'b0;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", lcd_data_oe, 1'b0);
    chk("rst_dout", lcd_data_out, 8'h00);
    chk("rst_ac", cursor_addr, 7'h00);
    chk("rst_flags", {display_on, cursor_on, blink_on}, 3'b000);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b1);

    // Busy window after reset release: fill plus long busy
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 80 + LC + 50) begin
      n++;
      @(negedge clk);
    end
    chk("rst_busy_len", n, 80 + LC);
    check_overlay("rst_overlay");
    bus_read(1'b0, "rst_status");

    // First data write and its status
    bus_write(1'b1, 8'h41, 1'b1);
    check_regs("wr41");
    bus_read(1'b0, "wr41_status");
    disp_addr = 7'h00; @(negedge clk);
    chk("wr41_overlay", disp_data, 8'h41);

    // Line-end wrap and out-of-range set AC
    bus_write(1'b0, 8'hA7, 1'b1);
    chk("setac_a7", cursor_addr, 7'h27);
    bus_write(1'b1, 8'h5A, 1'b1);
    chk("wrap_27_40", cursor_addr, 7'h40);
    disp_addr = 7'h27; @(negedge clk);
    chk("wr5a_overlay", disp_data, 8'h5A);
    bus_write(1'b0, 8'hB0, 1'b1);
    chk("setac_b0", cursor_addr, 7'h00);

    // Decrement mode wraps and data read at 0x40
    bus_write(1'b0, 8'h04, 1'b1);
    bus_write(1'b1, 8'h33, 1'b1);
    chk("wrap_00_67", cursor_addr, 7'h67);
    bus_write(1'b0, 8'hC0, 1'b1);
    bus_write(1'b1, 8'h77, 1'b1);
    chk("dec_40_27", cursor_addr, 7'h27);
    bus_write(1'b0, 8'hC0, 1'b1);
    bus_read(1'b1, "rd40");
    chk("rd40_ac", cursor_addr, 7'h27);
    bus_write(1'b0, 8'h06, 1'b1);

    // Writes and reads during busy
    bus_write(1'b1, 8'h11, 1'b0);
    bus_read(1'b0, "busy_status");
    bus_read(1'b1, "busy_dread");
    chk("busy_dread_ac", cursor_addr, m_ac);
    bus_write(1'b1, 8'h22, 1'b0);
    wait_not_busy();
    chk("overrun", overrun, m_ovr);
    check_regs("dropped");
    disp_addr = m_ac; @(negedge clk);
    chk("dropped_overlay", disp_data, m_overlay(int'(m_ac)));

    // Home takes the long busy
    bus_write(1'b0, 8'h02, 1'b1);
    chk("home_ac", cursor_addr, 7'h00);

    // Randomized command/data mix
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0, 1: bus_write(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        2:    bus_write(1'b0, 8'h80 | 8'($urandom_range(0, 127)), 1'b1);
        3:    bus_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)), 1'b1);
        4:    bus_write(1'b0, 8'h10 | 8'($urandom_range(0, 15)), 1'b1);
        5:    bus_write(1'b0, 8'h08 | 8'($urandom_range(0, 7)), 1'b1);
        6:    bus_read(1'b1, "rand_dread");
        default: begin
          bus_write(1'b0, 8'($urandom_range(32, 127)), 1'b1);
          bus_read(1'b0, "rand_status");
        end
      endcase
      check_regs("rand");
    end
    check_overlay("rand_overlay");

    // Clear with display on and decrement mode selected
    bus_write(1'b0, 8'h0F, 1'b1);
    bus_write(1'b0, 8'h04, 1'b1);
    bus_write(1'b0, 8'h01, 1'b1);
    check_regs("clear");
    check_overlay("clear_overlay");
    bus_write(1'b1, 8'h55, 1'b1);
    chk("clear_id_inc", cursor_addr, 7'h01);
    chk("final_overrun", overrun, m_ovr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

- Synthesizable model of the character-LCD side of the HD44780 8-bit parallel bus: the responder to the Avalon-driven LCD port.
- Samples asynchronous E/RS/RW/data pins, executes the command and data subset, and keeps an 80-byte DDRAM image.
- Returns busy/status and DDRAM reads on the bus.
- Exposes DDRAM plus display state on a second read port for an on-chip text overlay, and serves as a bench responder for LCD software.

## Interface
- BUSY_CYCLES, 1850: busy duration after a normal command or data write.
- BUSY_LONG_CYCLES, 76000: busy duration after clear/home, counted after the clear fill.
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- LCD_E in 1: enable strobe, asynchronous.
- LCD_RS in 1: 0 = instruction/status, 1 = data.
- LCD_RW in 1: 0 = write, 1 = read.
- lcd_data_in in 8: bus data from the host.
- lcd_data_out out 8: read data.
- lcd_data_oe out 1: bus drive enable.
- disp_addr in 7: overlay DDRAM address.
- disp_data out 8: overlay data, 1-cycle latency.
- cursor_addr out 7: current address counter (AC).
- display_on, cursor_on, blink_on out 1 each.
- busy out 1: busy flag.
- overrun out 1: sticky flag, set by a write accepted while busy.

## Operation
- **Input sampling:** E, RS, RW and data pass through an identical 2-flop synchronizer. A rise or fall of E is detected on the synchronized E.
  - On rise with RW=1: latch read data. RS=0 gives {busy, AC}; RS=1 gives DDRAM[AC].
  - On fall: the write or read is committed.
- **Bus drive:** lcd_data_oe = synchronized E & synchronized RW. lcd_data_out holds its latch.
- **State machine states:** IDLE, CLEAR, BUSY.
  - IDLE and no event: hold.
  - Write commit from IDLE executes immediately.
    - clear (0x01) → CLEAR.
    - Everything else → BUSY, counter loaded BUSY_CYCLES-1. Exception: home loads BUSY_LONG_CYCLES-1.
  - CLEAR: writes 0x20 to the 80 valid locations, one per cycle. Then sets AC=0 and I/D=1, loads BUSY_LONG_CYCLES-1, → BUSY.
  - BUSY: counts down; at 0 → IDLE.
  - busy=1 in every state except IDLE.
- **Instruction decode:** highest set bit selects the instruction.
  - 0x80|a: set AC. Any address outside 0x00–0x27 / 0x40–0x67 sets AC=0x00.
  - 0x40–0x7F (CGRAM): accepted, no effect, normal busy.
  - 0x20–0x3F (function set): stored, no effect. 4-bit mode is unsupported.
  - 0x10–0x1F: S/C=0 moves the cursor by R/L. S/C=1 (display shift) has no effect.
  - 0x08–0x0F: display_on = D, cursor_on = C, blink_on = B.
  - 0x04–0x07: I/D stored. S is ignored.
  - 0x02–0x03: home, AC=0.
  - 0x01: clear.
  - 0x00: no effect, normal busy.
- **Data:** a data write stores DDRAM[AC] then steps AC. A data read commit steps AC. Neither changes the busy state for a read.
- **AC step (wraps):** increment 0x27→0x40 and 0x67→0x00. Decrement 0x00→0x67 and 0x40→0x27.
- **Write while busy:** dropped, no state change; sets overrun (see Configuration). Status reads are always served.
- **Data read while busy:** returns the current DDRAM[AC]; no AC step.
- **Overlay reads:** disp_addr outside the valid ranges reads 0x20.

## Timing
- **Reset values:**
  - lcd_data_oe=0, lcd_data_out=0x00.
  - AC=0x00, I/D=1.
  - display_on=0, cursor_on=0, blink_on=0.
  - overrun=0.
  - state=CLEAR, so busy=1 from the first cycle after reset.
  - Reset asserted mid-fill or mid-busy restarts the fill.
- **Host requirements:**
  - E high ≥4 cycles and low ≥4 cycles.
  - RS, RW and data stable from ≥1 cycle before E rises to ≥3 cycles after E falls.
- **Latency:**
  - E fall on the pin → commit 3 cycles later; busy visible the cycle after commit.
  - E rise → lcd_data_out valid 4 cycles later.
  - oe follows E with 2 cycles of lag.
- Busy duration (normal command or data write): BUSY_CYCLES cycles.
- Busy duration (clear): 80 + BUSY_LONG_CYCLES cycles.

## Configuration
- LCD_RESP_OVERRUN_EN.
  - Defined: overrun is set by any write commit while busy=1 and clears only on reset.
  - Undefined: overrun is tied to 0 and the detect logic is absent.
  - Writes while busy are dropped in both cases.

## Structure
- **Package lcd_hd44780_pkg:**
  - instruction decode masks;
  - DDRAM bounds 0x27, 0x40, 0x67;
  - fill value 0x20;
  - state enum IDLE/CLEAR/BUSY.
- **Sub-module lcd_ddram:** 128×8 RAM with one write port and two registered read ports (bus, overlay).

## Test plan
- Reset release → busy=1 for 80+BUSY_LONG_CYCLES cycles; then every valid DDRAM location reads 0x20 via the overlay, and status reads 0x00.
- Data write 0x41 at AC=0 → DDRAM[0x00]=0x41, AC=0x01, busy for BUSY_CYCLES; status then reads 0x01.
- Set AC 0xA7, then data write 0x5A → DDRAM[0x27]=0x5A, AC=0x40. Set AC 0xB0 → AC=0x00.
- Entry mode 0x04, AC=0x00, data write → AC=0x67. Data read at 0x40 returns that byte and AC becomes 0x27.
- Data write immediately followed by a second data write during busy → the second write is dropped. overrun=1 with LCD_RESP_OVERRUN_EN defined, 0 without. A status read during busy returns 0x80|AC.
- Clear with display on (0x0F, then 0x01) → cursor/blink outputs unchanged, all DDRAM 0x20, AC=0, I/D=1, busy for 80+BUSY_LONG_CYCLES cycles.
